// File: rtl/scan_driver_if.sv
// scan_driver_if: digit mask / brightness in, anode drive / slot index / status out.
interface scan_driver_if #(
    parameter int NUM_DIGITS = 4,
    parameter int PERIOD = 8
);
    localparam int SW = $clog2(NUM_DIGITS);
    localparam int BW = $clog2(PERIOD + 1);
    logic [NUM_DIGITS-1:0] digit_en;
    logic [BW-1:0] bright;
    logic [NUM_DIGITS-1:0] AN;
    logic [SW-1:0] S;
    logic frame_start;
    logic blank;
    modport master (output digit_en, bright, input AN, S, frame_start, blank);
    modport slave (input digit_en, bright, output AN, S, frame_start, blank);
endinterface

// File: rtl/scan_driver.sv
// scan_driver: time-multiplexed anode scanner with digit masking, anti-ghost blanking and per-slot brightness.
module scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int PERIOD = 8,
    parameter int BLANK_CYCLES = 2,
    parameter bit AN_ACTIVE_LOW = 1
) (
    input logic clk_en,
    input logic clr,
    scan_driver_if.slave bus
);
    localparam int SW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(PERIOD);
    localparam int BW = $clog2(PERIOD + 1);
    localparam logic [9:0] BL = 10'(BLANK_CYCLES);
    localparam logic [9:0] MAX_ON = 10'(PERIOD - BLANK_CYCLES);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    // FRESH marks the slot entered by reset, whose brightness has not been sampled yet
    typedef enum logic [1:0] {ST_FRESH, ST_RUN, ST_IDLE} state_t;
    state_t st_q, st_d;
    logic [SW-1:0] s_q, s_d, lo, nx, idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] br_q, br_d;
    logic [NUM_DIGITS-1:0] an_q, an_d, onehot;
    logic fs_q, fs_d, blank_q, blank_d, any, wake, adv, active;
    logic [9:0] cnt_x, eff;
    always_ff @(posedge clk_en or posedge clr) begin
        if (clr) begin
            st_q <= ST_FRESH;
            s_q <= '0;
            cnt_q <= '0;
            br_q <= '0;
            an_q <= AN_OFF;
            fs_q <= 1'b0;
            blank_q <= 1'b1;
        end else begin
            st_q <= st_d;
            s_q <= s_d;
            cnt_q <= cnt_d;
            br_q <= br_d;
            an_q <= an_d;
            fs_q <= fs_d;
            blank_q <= blank_d;
        end
    end
    always_comb begin
        lo = '0;
        nx = s_q;
        idx = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--)
            if (bus.digit_en[k]) lo = SW'(k);
        // descending search so the nearest enabled index after S wins; k=NUM_DIGITS lands on S itself
        for (int k = NUM_DIGITS; k >= 1; k--) begin
            idx = SW'((int'(s_q) + k) % NUM_DIGITS);
            if (bus.digit_en[idx]) nx = idx;
        end
        any = |bus.digit_en;
        wake = any && st_q == ST_IDLE;
        adv = any && st_q != ST_IDLE && cnt_q == CW'(PERIOD - 1);
        st_d = any ? ST_RUN : ST_IDLE;
        s_d = wake ? lo : adv ? nx : s_q;
        cnt_d = (!any || wake || adv) ? '0 : cnt_q + CW'(1);
        br_d = (st_q == ST_FRESH || cnt_d == '0) ? bus.bright : br_q;
        cnt_x = 10'(cnt_d);
        eff = 10'(br_d) > MAX_ON ? MAX_ON : 10'(br_d);
        // unsigned wrap makes ticks inside the blank interval compare as large
        active = any && bus.digit_en[s_d] && (cnt_x - BL) < eff;
        onehot = active ? NUM_DIGITS'(1) << s_d : '0;
        an_d = AN_ACTIVE_LOW ? ~onehot : onehot;
        blank_d = !active;
        fs_d = (wake || adv) && s_d == lo;
    end
    assign bus.AN = an_q;
    assign bus.S = s_q;
    assign bus.frame_start = fs_q;
    assign bus.blank = blank_q;
endmodule

// File: tb/tb_scan_driver.sv
// tb_scan_driver: directed and random stimulus checked against a slot-level behavioural model.
module tb_scan_driver;
    localparam int N = 4;
    localparam int P = 8;
    localparam int B = 2;
    logic clk_en = 1'b0;
    logic clr = 1'b0;
    int n_assert = 0;
    int n_fail = 0;
    string phase = "init";
    int m_s, m_cnt, m_brq;
    bit m_idle, m_fresh, m_fs;
    logic [3:0] m_en;

    scan_driver_if #(.NUM_DIGITS(N), .PERIOD(P)) bus ();
    scan_driver #(.NUM_DIGITS(N), .PERIOD(P), .BLANK_CYCLES(B), .AN_ACTIVE_LOW(1'b1)) dut (
        .clk_en(clk_en),
        .clr(clr),
        .bus(bus)
    );

    always #5 clk_en = ~clk_en;

    function automatic int lowest(input logic [3:0] en);
        for (int i = 0; i < N; i++)
            if (en[i]) return i;
        return 0;
    endfunction

    function automatic int next_en(input int s, input logic [3:0] en);
        for (int k = 1; k <= N; k++)
            if (en[(s + k) % N]) return (s + k) % N;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s = 0; m_cnt = 0; m_brq = 0; m_idle = 0; m_fresh = 1; m_fs = 0; m_en = 4'h0;
    endtask

    task automatic model_step();
        logic [3:0] en;
        int br;
        en = bus.digit_en;
        br = int'(bus.bright);
        m_en = en;
        if (en == 4'h0) begin
            m_idle = 1; m_fresh = 0; m_cnt = 0; m_fs = 0;
        end else if (m_idle) begin
            m_idle = 0; m_fresh = 0; m_s = lowest(en); m_cnt = 0; m_brq = br; m_fs = 1;
        end else if (m_cnt == P - 1) begin
            m_s = next_en(m_s, en); m_cnt = 0; m_brq = br; m_fresh = 0;
            m_fs = (m_s == lowest(en));
        end else begin
            if (m_fresh) m_brq = br;
            m_fresh = 0; m_cnt++; m_fs = 0;
        end
    endtask

    task automatic check_outputs();
        int on_time;
        bit lit;
        logic [3:0] exp_an;
        on_time = (m_brq < P - B) ? m_brq : P - B;
        lit = (m_en != 4'h0) && m_en[m_s] && m_cnt >= B && m_cnt < B + on_time;
        exp_an = lit ? ~(4'(1) << m_s) : 4'hF;
        chk("AN", 32'(bus.AN), 32'(exp_an));
        chk("S", 32'(bus.S), 32'(m_s));
        chk("blank", 32'(bus.blank), 32'(!lit));
        chk("frame_start", 32'(bus.frame_start), 32'(m_fs));
    endtask

    task automatic tick();
        @(posedge clk_en);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        bus.digit_en = 4'hF;
        bus.bright = 4'd8;
        #2;
        phase = "async_reset";
        clr = 1'b1;
        #1;
        model_reset();
        chk("AN_rst", 32'(bus.AN), 32'hF);
        chk("S_rst", 32'(bus.S), 32'h0);
        chk("blank_rst", 32'(bus.blank), 32'h1);
        chk("fs_rst", 32'(bus.frame_start), 32'h0);
        @(posedge clk_en);
        #1;
        check_outputs();
        clr = 1'b0;

        phase = "all_on_b8";
        run(64);
        phase = "mask1010_b6";
        bus.digit_en = 4'b1010;
        bus.bright = 4'd6;
        run(40);
        phase = "bright3";
        bus.bright = 4'd3;
        run(16);
        phase = "bright0";
        bus.bright = 4'd0;
        run(16);
        phase = "bright15";
        bus.bright = 4'd15;
        run(16);
        phase = "bright_midslot";
        bus.digit_en = 4'hF;
        for (int i = 0; i < 48; i++) begin
            if (i % 5 == 2) bus.bright = 4'($urandom_range(0, 9));
            tick();
        end

        phase = "all_disabled";
        bus.digit_en = 4'h0;
        run(20);
        phase = "wake_single";
        bus.digit_en = 4'b0100;
        tick();
        chk("wake_S", 32'(bus.S), 32'd2);
        chk("wake_fs", 32'(bus.frame_start), 32'd1);
        run(24);

        phase = "clear_midslot";
        bus.digit_en = 4'hF;
        bus.bright = 4'd8;
        for (int i = 0; i < 20 && !(m_cnt == 3 && !m_idle); i++) tick();
        bus.digit_en = 4'hF & ~(4'(1) << m_s);
        tick();
        chk("cleared_AN", 32'(bus.AN), 32'hF);
        run(12);

        phase = "clr_midslot";
        bus.digit_en = 4'hF;
        for (int i = 0; i < 20 && m_cnt != 4; i++) tick();
        #2;
        clr = 1'b1;
        #1;
        model_reset();
        chk("AN_clr", 32'(bus.AN), 32'hF);
        chk("S_clr", 32'(bus.S), 32'h0);
        chk("blank_clr", 32'(bus.blank), 32'h1);
        check_outputs();
        #1;
        clr = 1'b0;
        run(40);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) bus.digit_en = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) bus.bright = 4'($urandom_range(0, 15));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
